// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/odd/even parity, 1 or 2 stop bits,
// 3-sample majority voting, false-start rejection, break handling and per-word error flags.
module uart_rx_cfg #(
  parameter int unsigned F         = 8000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 valid,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 perr,
  output logic                 ferr,
  output logic                 ovr
);

  localparam int unsigned MOD = (F + BAUD / 2) / BAUD;
  localparam int unsigned H   = MOD / 2;
  localparam int unsigned CW  = $clog2(MOD);
  localparam int unsigned BW  = 4;
  localparam logic PAR_EN  = (PARITY != 0);
  localparam logic PAR_ODD = (PARITY == 1);

  if (MOD < 8) begin : g_mod_chk
    $error("uart_rx_cfg: fewer than 8 clocks per bit");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_chk
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_par_chk
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4,
    S_BRK   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_m, rx_s;
  logic [CW-1:0]        ctx_q;
  logic                 s0_q, s1_q;
  logic [BW-1:0]        cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_acc_q, ferr_acc_q;

  logic bit_c, bt_c, done_c, ferr_new_c, perr_new_c, timer_idle_c;

  // Two-flop synchroniser, idle-high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign bit_c        = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign bt_c         = (ctx_q == CW'(H + 1)) && (state_q != S_IDLE) && (state_q != S_BRK);
  assign ferr_new_c   = ferr_acc_q | ~bit_c;
  assign perr_new_c   = PAR_EN ? (PAR_ODD ? ~par_acc_q : par_acc_q) : 1'b0;
  assign timer_idle_c = (state_q == S_IDLE) || (state_q == S_BRK) ||
                        (state_d == S_IDLE) || (state_d == S_BRK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; done_c marks the decision tick of the last stop bit
  always_comb begin
    state_d = state_q;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE:  if (!rx_s) state_d = S_START;
      S_START: if (bt_c) state_d = bit_c ? S_IDLE : S_DATA;
      S_DATA:  if (bt_c && cnt_q == BW'(DATA_BITS - 1)) state_d = PAR_EN ? S_PAR : S_STOP;
      S_PAR:   if (bt_c) state_d = S_STOP;
      S_STOP: begin
        if (bt_c && cnt_q == BW'(STOP_BITS - 1)) begin
          done_c  = 1'b1;
          state_d = ferr_new_c ? S_BRK : S_IDLE;
        end
      end
      S_BRK:   if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bit timer, samplers and frame accumulation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctx_q      <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      cnt_q      <= '0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      ferr_acc_q <= 1'b0;
    end else begin
      if (timer_idle_c)                ctx_q <= '0;
      else if (ctx_q == CW'(MOD - 1))  ctx_q <= '0;
      else                             ctx_q <= ctx_q + CW'(1);
      if (ctx_q == CW'(H - 1)) s0_q <= rx_s;
      if (ctx_q == CW'(H))     s1_q <= rx_s;
      if (bt_c) begin
        case (state_q)
          S_START: begin
            cnt_q      <= '0;
            par_acc_q  <= 1'b0;
            ferr_acc_q <= 1'b0;
          end
          S_DATA: begin
            shift_q   <= {bit_c, shift_q[DATA_BITS-1:1]};
            par_acc_q <= par_acc_q ^ bit_c;
            cnt_q     <= (cnt_q == BW'(DATA_BITS - 1)) ? '0 : cnt_q + BW'(1);
          end
          S_PAR: par_acc_q <= par_acc_q ^ bit_c;
          S_STOP: begin
            ferr_acc_q <= ferr_new_c;
            cnt_q      <= (cnt_q == BW'(STOP_BITS - 1)) ? '0 : cnt_q + BW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Output word register: load, overrun or consume
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
    end else if (done_c) begin
      if (!valid || ready) begin
        data  <= shift_q;
        perr  <= perr_new_c;
        ferr  <= ferr_new_c;
        ovr   <= 1'b0;
        valid <= 1'b1;
      end else begin
        ovr <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three configurations (8N1, 9E1, 8O2) on separate lines.
module tb_uart_rx_cfg;

  localparam int unsigned MOD = 69;
  localparam int unsigned H   = 34;
  // pin edge -> 2 sync flops + IDLE exit, then bt of the 10th bit (stop), then output register
  localparam int unsigned LAT_8N1 = 3 + (H + 1) + MOD * 9 + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ready = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

  logic       valid_a, perr_a, ferr_a, ovr_a;
  logic [7:0] data_a;
  logic       valid_b, perr_b, ferr_b, ovr_b;
  logic [8:0] data_b;
  logic       valid_c, perr_c, ferr_c, ovr_c;
  logic [7:0] data_c;

  uart_rx_cfg u_a (
    .clk(clk), .rst(rst), .rx(rx_a), .valid(valid_a), .ready(ready),
    .data(data_a), .perr(perr_a), .ferr(ferr_a), .ovr(ovr_a)
  );
  uart_rx_cfg #(.DATA_BITS(9), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .rx(rx_b), .valid(valid_b), .ready(ready),
    .data(data_b), .perr(perr_b), .ferr(ferr_b), .ovr(ovr_b)
  );
  uart_rx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_c (
    .clk(clk), .rst(rst), .rx(rx_c), .valid(valid_c), .ready(ready),
    .data(data_c), .perr(perr_c), .ferr(ferr_c), .ovr(ovr_c)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];
  int checks = 0, errors = 0;
  int unexp_a = 0, unexp_b = 0, unexp_c = 0;
  int cyc = 0;
  int rises_a = 0, rises_c = 0, last_rise_a = 0;
  logic va_prev = 1'b0, vc_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [8:0] d, input logic pe, input logic fe, input logic ov);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe; e.ov = ov;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Accepted words are compared against the scoreboard heads
  always @(negedge clk) begin
    exp_t e;
    if (rst && valid_a && ready) begin
      if (qa.size() == 0) unexp_a++;
      else begin
        e = qa.pop_front();
        chk("a_data", 32'(data_a), 32'(e.d[7:0]));
        chk("a_perr", 32'(perr_a), 32'(e.pe));
        chk("a_ferr", 32'(ferr_a), 32'(e.fe));
        chk("a_ovr",  32'(ovr_a),  32'(e.ov));
      end
    end
    if (rst && valid_b && ready) begin
      if (qb.size() == 0) unexp_b++;
      else begin
        e = qb.pop_front();
        chk("b_data", 32'(data_b), 32'(e.d));
        chk("b_perr", 32'(perr_b), 32'(e.pe));
        chk("b_ferr", 32'(ferr_b), 32'(e.fe));
      end
    end
    if (rst && valid_c && ready) begin
      if (qc.size() == 0) unexp_c++;
      else begin
        e = qc.pop_front();
        chk("c_data", 32'(data_c), 32'(e.d[7:0]));
        chk("c_perr", 32'(perr_c), 32'(e.pe));
        chk("c_ferr", 32'(ferr_c), 32'(e.fe));
      end
    end
    if (valid_a && !va_prev) begin
      rises_a++;
      last_rise_a = cyc;
    end
    if (valid_c && !vc_prev) rises_c++;
    va_prev = valid_a;
    vc_prev = valid_c;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int which, input logic v);
    case (which)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Drive one frame; optional 1-clk inverted spike, optional reset abort at a frame bit
  task automatic send(input int which, input logic [8:0] d, input int nb, input int pen,
                      input logic pbit, input int ns, input logic [1:0] sv,
                      input int sp_idx, input int sp_off, input int abort_idx);
    logic [15:0] fr;
    int n;
    fr = '0;
    n = 1;
    for (int i = 0; i < nb; i++) begin fr[n] = d[i]; n++; end
    if (pen != 0) begin fr[n] = pbit; n++; end
    for (int i = 0; i < ns; i++) begin fr[n] = sv[i]; n++; end
    for (int i = 0; i < n; i++) begin
      set_rx(which, fr[i]);
      if (i == abort_idx) begin
        tick(30);
        rst = 1'b0;
        set_rx(which, 1'b1);
        return;
      end
      if (i == sp_idx) begin
        tick(sp_off);
        set_rx(which, ~fr[i]);
        tick(1);
        set_rx(which, fr[i]);
        tick(MOD - sp_off - 1);
      end else begin
        tick(MOD);
      end
    end
  endtask

  initial begin
    int t0, r0;
    logic p;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_data",  32'(data_a),  0);
    chk("rst_perr",  32'(perr_a),  0);
    chk("rst_ferr",  32'(ferr_a),  0);
    chk("rst_ovr",   32'(ovr_a),   0);
    rst = 1'b1;
    tick(5);

    // 8N1 0x55 with latency check
    qa.push_back(mk(9'h055, 0, 0, 0));
    t0 = cyc;
    send(0, 9'h055, 8, 0, 1'b0, 1, 2'b01, -1, 0, -1);
    chk("a_latency", 32'(last_rise_a - t0), 32'(LAT_8N1));
    chk("a_pulses", 32'(rises_a), 1);

    // False start
    r0 = rises_a;
    rx_a = 1'b0;
    tick(20);
    rx_a = 1'b1;
    tick(200);
    chk("a_glitch", 32'(rises_a - r0), 0);

    // Single-clock spikes at sampling points inside data bits
    qa.push_back(mk(9'h000, 0, 0, 0));
    send(0, 9'h000, 8, 0, 1'b0, 1, 2'b01, 3, 35, -1);
    tick(20);
    qa.push_back(mk(9'h0FF, 0, 0, 0));
    send(0, 9'h0FF, 8, 0, 1'b0, 1, 2'b01, 6, 34, -1);
    tick(20);

    // 9-bit even parity: 0x1A3 has five ones, so parity bit 1 is correct
    qb.push_back(mk(9'h1A3, 0, 0, 0));
    send(1, 9'h1A3, 9, 1, 1'b1, 1, 2'b01, -1, 0, -1);
    tick(10);
    qb.push_back(mk(9'h1A3, 1, 0, 0));
    send(1, 9'h1A3, 9, 1, 1'b0, 1, 2'b01, -1, 0, -1);
    tick(10);

    // Odd parity, 2 stops, second stop 0, then line held low
    p = ~^8'h5A;
    r0 = rises_c;
    qc.push_back(mk(9'h05A, 0, 1, 0));
    send(2, 9'h05A, 8, 1, p, 2, 2'b01, -1, 0, -1);
    tick(2000);
    chk("c_brk_words", 32'(rises_c - r0), 1);
    rx_c = 1'b1;
    tick(100);
    p = ~^8'h0F;
    qc.push_back(mk(9'h00F, 0, 0, 0));
    send(2, 9'h00F, 8, 1, p, 2, 2'b11, -1, 0, -1);
    tick(10);

    // Overrun with ready low
    ready = 1'b0;
    qa.push_back(mk(9'h011, 0, 0, 1));
    send(0, 9'h011, 8, 0, 1'b0, 1, 2'b01, -1, 0, -1);
    tick(5);
    chk("a_hold_valid", 32'(valid_a), 1);
    chk("a_hold_ovr0",  32'(ovr_a),   0);
    send(0, 9'h022, 8, 0, 1'b0, 1, 2'b01, -1, 0, -1);
    tick(5);
    chk("a_ovr_set",  32'(ovr_a),  1);
    chk("a_ovr_data", 32'(data_a), 32'h11);
    ready = 1'b1;
    tick(1);
    chk("a_consumed", 32'(valid_a), 0);
    qa.push_back(mk(9'h033, 0, 0, 0));
    send(0, 9'h033, 8, 0, 1'b0, 1, 2'b01, -1, 0, -1);
    tick(10);

    // Reset during data bit 3 (frame bit 4)
    send(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b01, -1, 0, 4);
    tick(3);
    chk("mid_rst_valid", 32'(valid_a), 0);
    chk("mid_rst_data",  32'(data_a),  0);
    chk("mid_rst_perr",  32'(perr_a),  0);
    chk("mid_rst_ferr",  32'(ferr_a),  0);
    chk("mid_rst_ovr",   32'(ovr_a),   0);
    rst = 1'b1;
    tick(10);
    qa.push_back(mk(9'h0C4, 0, 0, 0));
    send(0, 9'h0C4, 8, 0, 1'b0, 1, 2'b01, -1, 0, -1);

    for (int i = 0; i < 500 && (qa.size() + qb.size() + qc.size()) != 0; i++) tick(1);
    chk("qa_left", 32'(qa.size()), 0);
    chk("qb_left", 32'(qb.size()), 0);
    chk("qc_left", 32'(qc.size()), 0);
    chk("a_extra", 32'(unexp_a), 0);
    chk("b_extra", 32'(unexp_b), 0);
    chk("c_extra", 32'(unexp_c), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
